cmp_minmax_seq: RTL and testbench

- Sequential min/max finder over a burst of unsigned samples.
- Shares one magnitude comparator instance across both compare operations: first against the running maximum, then against the running minimum.
- Sits between a sample source (valid/ready) and a consumer of the result. The consumer reads max/min values and their indices on a one-cycle done pulse.
- Controller FSM sequences the comparator operand muxes and the result registers.

---
 rtl/cmp_minmax_pkg.sv | 20 ++
 rtl/comparator_4bit.sv | 19 +
 rtl/cmp_minmax_seq.sv | 166 ++++++++++++++++
 tb/tb_cmp_minmax_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_minmax_pkg.sv
// rtl/cmp_minmax_pkg.sv - shared defaults and controller state encoding for cmp_minmax_seq
// Contents:
//   WIDTH_DEF   default sample width
//   MAX_LEN_DEF default maximum burst length
//   state_e     controller states, 3-bit encoding
package cmp_minmax_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    GET     = 3'd2,
    CMP_MAX = 3'd3,
    CMP_MIN = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/comparator_4bit.sv
// rtl/comparator_4bit.sv - combinational unsigned magnitude comparator
// Ports:
//   a_i      in  WIDTH  operand A
//   b_i      in  WIDTH  operand B
//   a_gt_b_o out 1      A > B (unsigned)
//   a_lt_b_o out 1      A < B (unsigned)
module comparator_4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             a_gt_b_o,
  output logic             a_lt_b_o
);

  assign a_gt_b_o = (a_i > b_i);
  assign a_lt_b_o = (a_i < b_i);

endmodule

// File: rtl/cmp_minmax_seq.sv
// rtl/cmp_minmax_seq.sv - sequential min/max finder over a burst of unsigned samples
// Ports:
//   clk       in  1      clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   start     in  1      begin a burst (sampled only in IDLE)
//   len       in  LEN_W  burst length 1..MAX_LEN, captured with start
//   in_valid  in  1      sample valid
//   in_data   in  WIDTH  unsigned sample
//   in_ready  out 1      sample accepted this cycle when in_valid is high
//   busy      out 1      high outside IDLE
//   done      out 1      one-cycle pulse, results valid
//   max_val   out WIDTH  largest sample of the last burst
//   min_val   out WIDTH  smallest sample of the last burst
//   max_idx   out IDX_W  index of first occurrence of max
//   min_idx   out IDX_W  index of first occurrence of min
module cmp_minmax_seq
  import cmp_minmax_pkg::*;
#(
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int MAX_LEN = MAX_LEN_DEF,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1,
  localparam int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx
);

  state_e state_q, state_d;

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;

  logic             len_ok;
  logic [LEN_W-1:0] cnt_inc;
  logic [WIDTH-1:0] cmp_b;
  logic             a_gt_b;
  logic             a_lt_b;

  assign len_ok  = (len >= LEN_W'(1)) && (len <= LEN_W'(MAX_LEN));
  assign cnt_inc = cnt_q + LEN_W'(1);

  // One comparator serves both compare states; only the B operand changes.
  assign cmp_b = (state_q == CMP_MIN) ? min_q : max_q;

  comparator_4bit #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a_i      (s_q),
    .b_i      (cmp_b),
    .a_gt_b_o (a_gt_b),
    .a_lt_b_o (a_lt_b)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    s_d       = s_q;
    idx_d     = idx_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;

    unique case (state_q)
      IDLE: begin
        if (start && len_ok) begin
          len_d   = len;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The first sample seeds both extremes; results of the previous
        // burst stay visible until this transfer.
        if (in_valid) begin
          max_d     = in_data;
          min_d     = in_data;
          max_idx_d = '0;
          min_idx_d = '0;
          cnt_d     = LEN_W'(1);
          state_d   = (len_q == LEN_W'(1)) ? DONE : GET;
        end
      end
      GET: begin
        if (in_valid) begin
          s_d     = in_data;
          idx_d   = cnt_q[IDX_W-1:0];
          state_d = CMP_MAX;
        end
      end
      CMP_MAX: begin
        // Strict compare keeps the earliest index on ties.
        if (a_gt_b) begin
          max_d     = s_q;
          max_idx_d = idx_q;
        end
        state_d = CMP_MIN;
      end
      CMP_MIN: begin
        if (a_lt_b) begin
          min_d     = s_q;
          min_idx_d = idx_q;
        end
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? DONE : GET;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      s_q       <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      s_q       <= s_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign in_ready = (state_q == LOAD) || (state_q == GET);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign max_val  = max_q;
  assign min_val  = min_q;
  assign max_idx  = max_idx_q;
  assign min_idx  = min_idx_q;

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// tb/tb_cmp_minmax_seq.sv - directed self-checking bench for cmp_minmax_seq
module tb_cmp_minmax_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] len;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [3:0] max_val;
  logic [3:0] min_val;
  logic [3:0] max_idx;
  logic [3:0] min_idx;

  int total = 0;
  int bad   = 0;

  logic [3:0] samp [16];
  int         lat;
  int         nready;

  cmp_minmax_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
    .min_val  (min_val),
    .max_idx  (max_idx),
    .min_idx  (min_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input logic [3:0] mx, input logic [3:0] mxi,
                               input logic [3:0] mn, input logic [3:0] mni);
    check({tag, ".max_val"}, 32'(max_val), 32'(mx));
    check({tag, ".max_idx"}, 32'(max_idx), 32'(mxi));
    check({tag, ".min_val"}, 32'(min_val), 32'(mn));
    check({tag, ".min_idx"}, 32'(min_idx), 32'(mni));
  endtask

  // Starts a burst of n samples from samp[] with in_valid held high.
  // lat = cycles from the LOAD transfer cycle to the done cycle (1 = next cycle).
  // nready = cycles with in_ready high during the burst.
  task automatic run_burst(input int n, output int lat_o, output int nready_o);
    int k;
    int cyc;
    int load_cyc;
    bit xfer;
    bit seen;
    k = 0; cyc = 0; load_cyc = -1; seen = 0; lat_o = -1; nready_o = 0;
    start = 1'b1;
    len   = 5'(n);
    tick();
    start = 1'b0;
    while (!seen && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = samp[(k < 16) ? k : 15];
      xfer     = in_ready;
      if (in_ready) nready_o++;
      tick();
      cyc++;
      if (xfer) begin
        if (k == 0) load_cyc = cyc;
        k++;
      end
      if (done) begin
        seen  = 1;
        lat_o = cyc - load_cyc + 1;
      end
    end
    in_valid = 1'b0;
    check("burst_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.busy",     32'(busy),     32'd0);
    check("rst.done",     32'(done),     32'd0);
    check_results("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle.busy",     32'(busy),     32'd0);
    check("idle.in_ready", 32'(in_ready), 32'd0);

    // Basic burst
    samp[0] = 4'd5; samp[1] = 4'd3; samp[2] = 4'd9; samp[3] = 4'd3;
    run_burst(4, lat, nready);
    check("basic.latency", 32'(lat), 32'd10);
    check("basic.nready",  32'(nready), 32'd4);
    check_results("basic", 4'd9, 4'd2, 4'd3, 4'd1);
    tick();
    check("basic.done_pulse", 32'(done), 32'd0);
    check("basic.idle",       32'(busy), 32'd0);

    // Single sample; previous results remain visible while waiting in LOAD
    start = 1'b1; len = 5'd1; tick(); start = 1'b0;
    check("single.wait_ready", 32'(in_ready), 32'd1);
    check("single.hold_max",   32'(max_val),  32'd9);
    in_valid = 1'b1; in_data = 4'd7; tick(); in_valid = 1'b0;
    check("single.done", 32'(done), 32'd1);
    check_results("single", 4'd7, 4'd0, 4'd7, 4'd0);
    tick();
    check("single.done_pulse", 32'(done), 32'd0);

    // Full length ascending
    for (int i = 0; i < 16; i++) samp[i] = 4'(i);
    run_burst(16, lat, nready);
    check("asc.latency", 32'(lat), 32'd46);
    check_results("asc", 4'd15, 4'd15, 4'd0, 4'd0);
    tick();

    // Full length descending
    for (int i = 0; i < 16; i++) samp[i] = 4'(15 - i);
    run_burst(16, lat, nready);
    check_results("desc", 4'd15, 4'd0, 4'd0, 4'd15);
    tick();

    // Handshake stalls with start pulsed mid-burst
    start = 1'b1; len = 5'd3; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'h4;
    check("stall.load_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_data = 4'hF; start = 1'b1; len = 5'd2;
    tick();
    check("stall.get_wait_ready", 32'(in_ready), 32'd1);
    check("stall.busy",           32'(busy),     32'd1);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    check("stall.cmpmax_ready", 32'(in_ready), 32'd0);
    in_data = 4'h0;
    tick();
    check("stall.cmpmin_ready", 32'(in_ready), 32'd0);
    tick();
    check("stall.get_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("stall.cmpmax2_ready", 32'(in_ready), 32'd0);
    tick();
    check("stall.cmpmin2_done", 32'(done), 32'd0);
    tick();
    check("stall.done", 32'(done), 32'd1);
    check_results("stall", 4'hF, 4'd1, 4'h0, 4'd2);
    tick();
    check("stall.idle",      32'(busy), 32'd0);
    check("stall.no_restart", 32'(in_ready), 32'd0);

    // Abort during CMP_MAX
    start = 1'b1; len = 5'd4; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd2; tick();
    in_data = 4'd8; tick();
    in_valid = 1'b0;
    check("abort.cmpmax_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort.busy",     32'(busy),     32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd0);
    check("abort.done",     32'(done),     32'd0);
    check_results("abort", 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    begin
      int dcount;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done) dcount++;
      end
      check("abort.no_done", 32'(dcount), 32'd0);
    end

    // Illegal lengths
    start = 1'b1; len = 5'd0; tick(); start = 1'b0;
    check("len0.busy", 32'(busy), 32'd0);
    start = 1'b1; len = 5'd17; tick(); start = 1'b0;
    check("len17.busy", 32'(busy), 32'd0);
    tick();
    check("illegal.in_ready", 32'(in_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
